// File: rtl/mac_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mac_seq_ctrl
// Brief    : Dot-product sequencer around an iterative signed radix-4 Booth
//            multiplier. One start command clears the accumulator, takes N
//            operand pairs over valid/ready, multiplies each pair one Booth
//            digit per cycle, and adds every product into the accumulator.
//            Optional macro MAC_SAT_EN makes the accumulator saturate on
//            signed overflow instead of wrapping.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [OUT_WIDTH-1:0]  acc_out,
  output logic                  done,
  output logic                  ovf
);

  localparam int STEPS  = DATA_WIDTH / 2;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PP_W   = DATA_WIDTH + 2;   // wide enough for +/-2a of the most negative a
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [LEN_WIDTH-1:0] CNT_ONE   = LEN_WIDTH'(1);

`ifdef MAC_SAT_EN
  localparam logic [OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  // Multiplier shifted right two bits per step; bit 0 holds the implicit b[-1]=0.
  logic [DATA_WIDTH:0]   mult_q, mult_d;
  logic [PROD_W-1:0]     prod_q, prod_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  acc_q, acc_d;
  logic                  ovf_q, ovf_d;

  logic [PP_W-1:0]       pp;
  logic [PROD_W-1:0]     pp_shifted;
  logic [PROD_W-1:0]     prod_sum;
  logic [OUT_WIDTH-1:0]  prod_sext;
  logic [OUT_WIDTH-1:0]  acc_sum;
  logic                  add_ovf;
  logic [OUT_WIDTH-1:0]  acc_new;

  // Booth partial product for the current digit, shifted into place and summed.
  always_comb begin
    logic [PP_W-1:0] a_ext;
    a_ext = PP_W'($signed(a_q));
    pp    = '0;
    case (mult_q[2:0])
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = -(a_ext << 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
    pp_shifted = PROD_W'($signed(pp)) << {step_q, 1'b0};
    prod_sum   = prod_q + pp_shifted;
  end

  // Accumulate the finished product, detect signed overflow, optionally clamp.
  always_comb begin
    prod_sext = OUT_WIDTH'($signed(prod_q));
    acc_sum   = acc_q + prod_sext;
    add_ovf   = (acc_q[OUT_WIDTH-1] == prod_sext[OUT_WIDTH-1]) &&
                (acc_sum[OUT_WIDTH-1] != acc_q[OUT_WIDTH-1]);
`ifdef MAC_SAT_EN
    // On overflow both operands share a sign, which is the sign of the true sum.
    if (add_ovf) begin
      acc_new = acc_q[OUT_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_new = acc_sum;
    end
`else
    acc_new = acc_sum;
`endif
  end

  // Next-state and handshake outputs for the sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    mult_d   = mult_q;
    prod_d   = prod_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    done     = 1'b0;
    in_ready = 1'b0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          mult_d  = {b, 1'b0};
          prod_d  = '0;
          step_d  = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d = prod_sum;
        mult_d = mult_q >> 2;
        if (step_q == STEP_LAST) begin
          step_d  = '0;
          state_d = S_ACC;
        end else begin
          step_d  = step_q + STEP_W'(1);
        end
      end
      S_ACC: begin
        acc_d = acc_new;
        ovf_d = ovf_q | add_ovf;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any pair in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      mult_q  <= '0;
      prod_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mult_q  <= mult_d;
      prod_q  <= prod_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out = acc_q;
  assign ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mac_seq_ctrl
// Brief    : Scoreboard bench for mac_seq_ctrl. Each dot product's expected
//            result, overflow flag and completion cycle come from an
//            arithmetic model and are queued; a monitor compares on done.
//            Honours MAC_SAT_EN the same way as the design.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_seq_ctrl;

  localparam int DW  = 16;
  localparam int OW  = 32;
  localparam int LW  = 8;
  localparam int LAT = DW / 2 + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [OW-1:0] acc_out;
  logic          done;
  logic          ovf;

  mac_seq_ctrl #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .acc_out(acc_out), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] acc;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   pa[16];
  int   pb[16];
  int   pg[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Dot product from plain signed arithmetic; completion cycle from pair count and stalls.
  function automatic exp_t model(input int n, input int sc);
    exp_t          e;
    longint        acc, prod, s;
    longint        maxv, minv;
    logic [OW-1:0] t;
    int            stall;
    maxv  = (64'sd1 <<< (OW - 1)) - 1;
    minv  = -(64'sd1 <<< (OW - 1));
    acc   = 0;
    stall = 0;
    e.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      prod  = longint'(pa[i]) * longint'(pb[i]);
      s     = acc + prod;
      stall = stall + pg[i];
      if (s > maxv || s < minv) begin
        e.ovf = 1'b1;
`ifdef MAC_SAT_EN
        acc = (s > maxv) ? maxv : minv;
`else
        t   = s[OW-1:0];
        acc = longint'($signed(t));
`endif
      end else begin
        acc = s;
      end
    end
    e.acc = acc[OW-1:0];
    e.cyc = sc + LAT * n + stall;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done=1 expected none (cyc=%0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("acc_out", {32'd0, acc_out}, {32'd0, e.acc});
        chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic set_pair(input int i, input int x, input int y, input int g);
    pa[i] = x;
    pb[i] = y;
    pg[i] = g;
  endtask

  function automatic int rand_op();
    case ($urandom_range(0, 7))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Feed n pairs; pg[i] idle cycles in LOAD before pair i, with stray start pulses then.
  task automatic drive_pairs(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      a = pa[i][DW-1:0];
      b = pb[i][DW-1:0];
      t = 0;
      while (!in_ready && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout got 0 expected 1 (pair %0d)", i);
        return;
      end
      for (int g = 0; g < pg[i]; g++) begin
        start = 1'b1;
        len   = LW'($urandom_range(0, 255));
        @(negedge clk);
        start = 1'b0;
      end
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = DW'($urandom);
      b = DW'($urandom);
    end
  endtask

  task automatic run(input int n);
    int sc;
    int t;
    @(negedge clk);
    sc = cyc + 1;
    sbq.push_back(model(n, sc));
    start = 1'b1;
    len   = LW'(n);
    @(negedge clk);
    start = 1'b0;
    len   = LW'($urandom_range(0, 255));
    if (n == 0) chk("len0_in_ready", {63'd0, in_ready}, 64'd0);
    drive_pairs(n);
    t = 0;
    #1;
    while (sbq.size() != 0 && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done expected done (n=%0d)", n);
      sbq.delete();
    end
    @(negedge clk);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_idle_outputs();
    chk("rst_acc_out", {32'd0, acc_out}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int n;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs();

    // Single pair and the basic three-pair vector.
    set_pair(0, 15, 5, 0);
    run(1);
    set_pair(0, 15, 5, 0); set_pair(1, 10, 29, 0); set_pair(2, 7, 5, 0);
    run(3);
    // Mixed signs, then the most negative operand squared.
    set_pair(0, 3, -2, 0); set_pair(1, -6, 6, 0); set_pair(2, -2, -2, 0);
    run(3);
    set_pair(0, -32768, -32768, 0);
    run(1);
    // Empty vector.
    run(0);
    // Backpressure between pairs, with start pulsed while busy.
    set_pair(0, 15, 5, 0); set_pair(1, 10, 29, 3); set_pair(2, 7, 5, 3);
    run(3);

    // Reset during the fifth Booth step of the second pair.
    set_pair(0, 15, 5, 0); set_pair(1, 10, 29, 0);
    @(negedge clk);
    sc    = cyc + 1;
    start = 1'b1;
    len   = LW'(3);
    @(negedge clk);
    start = 1'b0;
    drive_pairs(2);
    while (cyc < sc + 15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs();
    set_pair(0, 7, 5, 0);
    run(1);

    // Repeated overflow: wraps or saturates depending on build.
    for (int i = 0; i < 3; i++) set_pair(i, -32768, -32768, 0);
    run(3);

    // Random vectors.
    for (int k = 0; k < 30; k++) begin
      n = (k % 7 == 6) ? 0 : int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) set_pair(i, rand_op(), rand_op(), int'($urandom_range(0, 3)));
      run(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
